// File: rtl/sdram_req_sequencer.sv
// Front-end sequencer for sdram_controller: queues host read/write commands and issues them one at a time,
// waiting for data_valid (or a timeout) and an idle gap between commands.
module sdram_req_sequencer #(
   parameter int DEPTH      = 4,
   parameter int TIMEOUT    = 16,
   parameter int GAP_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   host_valid,
   input  logic                   host_write,
   output logic                   host_ready,
   output logic                   read_req,
   output logic                   write_req,
   input  logic                   data_valid,
   output logic                   done,
   output logic                   done_write,
   output logic                   timeout,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int PW         = $clog2(DEPTH);
   localparam int CNTW       = PW + 1;
   localparam int CW         = $clog2(TIMEOUT + GAP_CYCLES + 1);
   localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LAST_I);

   typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

   // With no gap configured, completion returns straight to IDLE.
   localparam state_t AFTER_DONE = (GAP_CYCLES == 0) ? IDLE : GAP;

   state_t          r_state, w_state_next;
   logic [DEPTH-1:0] r_mem;
   logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [CNTW-1:0] r_count;
   logic [CW-1:0]   r_cnt, w_cnt_next;
   logic            r_cur_write, w_cur_write_next;
   logic            r_read_req, r_write_req, r_done, r_done_write, r_timeout;
   logic            w_read_req_next, w_write_req_next, w_done_next, w_done_write_next, w_timeout_next;
   logic            w_push, w_pop, w_head;

   assign host_ready = (r_count < CNTW'(DEPTH));
   assign w_push     = host_valid && host_ready;
   assign w_head     = r_mem[r_rd_ptr];

   assign read_req   = r_read_req;
   assign write_req  = r_write_req;
   assign done       = r_done;
   assign done_write = r_done_write;
   assign timeout    = r_timeout;
   assign fifo_count = r_count;
   assign busy       = (r_state != IDLE) || (r_count != '0);

   // Command FIFO: one type bit per entry; simultaneous push and pop keep the count steady.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= host_write;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNTW'(1);
            2'b01:   r_count <= r_count - CNTW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FSM state and registered pulse outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_cur_write  <= 1'b0;
         r_read_req   <= 1'b0;
         r_write_req  <= 1'b0;
         r_done       <= 1'b0;
         r_done_write <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_cur_write  <= w_cur_write_next;
         r_read_req   <= w_read_req_next;
         r_write_req  <= w_write_req_next;
         r_done       <= w_done_next;
         r_done_write <= w_done_write_next;
         r_timeout    <= w_timeout_next;
      end
   end

   // Next-state logic; data_valid is checked before the timeout limit so it wins a tie.
   always_comb begin
      w_state_next      = r_state;
      w_cnt_next        = r_cnt;
      w_cur_write_next  = r_cur_write;
      w_read_req_next   = 1'b0;
      w_write_req_next  = 1'b0;
      w_done_next       = 1'b0;
      w_done_write_next = 1'b0;
      w_timeout_next    = 1'b0;
      w_pop             = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_count != '0) begin
               w_pop            = 1'b1;
               w_read_req_next  = !w_head;
               w_write_req_next = w_head;
               w_cur_write_next = w_head;
               w_cnt_next       = '0;
               w_state_next     = WAIT;
            end
         end
         WAIT: begin
            if (data_valid) begin
               w_done_next       = 1'b1;
               w_done_write_next = r_cur_write;
               w_cnt_next        = '0;
               w_state_next      = AFTER_DONE;
            end else if (r_cnt == TO_LAST) begin
               w_timeout_next    = 1'b1;
               w_done_write_next = r_cur_write;
               w_cnt_next        = '0;
               w_state_next      = AFTER_DONE;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_cnt_next   = '0;
               w_state_next = IDLE;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sdram_req_sequencer.sv
// Directed self-checking bench for sdram_req_sequencer with DEPTH=4, TIMEOUT=16, GAP_CYCLES=2.
module tb_sdram_req_sequencer;

   logic       clk;
   logic       reset;
   logic       host_valid;
   logic       host_write;
   logic       host_ready;
   logic       read_req;
   logic       write_req;
   logic       data_valid;
   logic       done;
   logic       done_write;
   logic       timeout;
   logic       busy;
   logic [2:0] fifo_count;

   int testsRun;
   int testsFailed;

   sdram_req_sequencer #(.DEPTH(4), .TIMEOUT(16), .GAP_CYCLES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .host_valid (host_valid),
      .host_write (host_write),
      .host_ready (host_ready),
      .read_req   (read_req),
      .write_req  (write_req),
      .data_valid (data_valid),
      .done       (done),
      .done_write (done_write),
      .timeout    (timeout),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Present one host command for exactly one edge.
   task automatic applyStimulus(input logic isWrite);
      host_valid = 1'b1;
      host_write = isWrite;
      tick();
      host_valid = 1'b0;
      host_write = 1'b0;
   endtask

   // Wait (bounded) for the next request pulse, check its type, then answer with data_valid.
   task automatic serveOne(input logic expWrite, input string tag);
      int  n;
      logic found;
      n = 0;
      found = 1'b0;
      while (!found && n < 40) begin
         tick();
         n++;
         if (read_req || write_req) found = 1'b1;
      end
      checkOutput({tag, "_issued"}, found, 1);
      checkOutput({tag, "_type"}, write_req, expWrite);
      checkOutput({tag, "_excl"}, read_req & write_req, 0);
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      checkOutput({tag, "_done"}, done, 1);
      checkOutput({tag, "_done_write"}, done_write, expWrite);
      checkOutput({tag, "_no_timeout"}, timeout, 0);
   endtask

   initial begin
      logic seen;
      testsRun    = 0;
      testsFailed = 0;
      reset       = 1'b1;
      host_valid  = 1'b0;
      host_write  = 1'b0;
      data_valid  = 1'b0;

      // Reset values
      tick();
      tick();
      checkOutput("rst_count", fifo_count, 0);
      checkOutput("rst_ready", host_ready, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_reqs", {read_req, write_req, done, done_write, timeout}, 0);
      reset = 1'b0;
      tick();

      // Single write: pulse at k+1, data_valid answered, busy drops two cycles after done
      applyStimulus(1'b1);
      checkOutput("w1_count_k", fifo_count, 1);
      checkOutput("w1_busy_k", busy, 1);
      checkOutput("w1_wreq_k", write_req, 0);
      tick();
      checkOutput("w1_wreq_k1", write_req, 1);
      checkOutput("w1_rreq_k1", read_req, 0);
      checkOutput("w1_count_k1", fifo_count, 0);
      tick();
      checkOutput("w1_wreq_k2", write_req, 0);
      tick();
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      checkOutput("w1_done", done, 1);
      checkOutput("w1_done_write", done_write, 1);
      checkOutput("w1_timeout", timeout, 0);
      tick();
      checkOutput("w1_done_drop", done, 0);
      checkOutput("w1_busy_gap", busy, 1);
      tick();
      checkOutput("w1_busy_idle", busy, 0);

      // Stalled controller: read A outstanding, then W,R,R,W fill the FIFO
      host_valid = 1'b1;
      host_write = 1'b0;
      tick();
      host_write = 1'b1;
      tick();
      checkOutput("fill_a_rreq", read_req, 1);
      checkOutput("fill_count1", fifo_count, 1);
      host_write = 1'b0;
      tick();
      checkOutput("fill_count2", fifo_count, 2);
      tick();
      checkOutput("fill_count3", fifo_count, 3);
      host_write = 1'b1;
      tick();
      checkOutput("fill_count4", fifo_count, 4);
      checkOutput("fill_ready0", host_ready, 0);
      host_write = 1'b0;
      tick();
      tick();
      checkOutput("fill_5th_count", fifo_count, 4);
      checkOutput("fill_5th_ready", host_ready, 0);
      host_valid = 1'b0;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      checkOutput("fill_a_done", done, 1);
      checkOutput("fill_a_done_write", done_write, 0);
      checkOutput("fill_a_count", fifo_count, 4);
      serveOne(1'b1, "q0");
      serveOne(1'b0, "q1");
      serveOne(1'b0, "q2");
      serveOne(1'b1, "q3");
      repeat (6) tick();
      checkOutput("fill_drained_busy", busy, 0);
      checkOutput("fill_drained_count", fifo_count, 0);

      // Timeout on a read, with a write queued behind it
      applyStimulus(1'b0);
      host_valid = 1'b1;
      host_write = 1'b1;
      tick();
      host_valid = 1'b0;
      host_write = 1'b0;
      checkOutput("to_rreq", read_req, 1);
      checkOutput("to_count", fifo_count, 1);
      seen = 1'b0;
      repeat (15) begin
         tick();
         seen |= timeout | done | write_req | read_req;
      end
      checkOutput("to_early", seen, 0);
      tick();
      checkOutput("to_timeout", timeout, 1);
      checkOutput("to_done", done, 0);
      checkOutput("to_done_write", done_write, 0);
      tick();
      checkOutput("to_timeout_drop", timeout, 0);
      checkOutput("to_wreq_gap1", write_req, 0);
      tick();
      checkOutput("to_wreq_gap2", write_req, 0);
      tick();
      checkOutput("to_wreq_issue", write_req, 1);
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      checkOutput("to_next_done", done, 1);
      checkOutput("to_next_done_write", done_write, 1);
      repeat (3) tick();

      // data_valid on the same edge as the timeout limit
      applyStimulus(1'b0);
      tick();
      checkOutput("tie_rreq", read_req, 1);
      repeat (15) tick();
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      checkOutput("tie_done", done, 1);
      checkOutput("tie_timeout", timeout, 0);
      checkOutput("tie_done_write", done_write, 0);
      repeat (3) tick();

      // data_valid in IDLE and in GAP is ignored
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      checkOutput("idle_dv_done", done, 0);
      checkOutput("idle_dv_busy", busy, 0);
      checkOutput("idle_dv_count", fifo_count, 0);
      applyStimulus(1'b1);
      serveOne(1'b1, "gapcmd");
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      checkOutput("gap_dv_done", done, 0);
      checkOutput("gap_dv_timeout", timeout, 0);
      checkOutput("gap_dv_busy", busy, 1);
      tick();
      checkOutput("gap_dv_idle", busy, 0);
      checkOutput("gap_dv_count", fifo_count, 0);

      // Asynchronous reset during WAIT with two commands queued
      applyStimulus(1'b0);
      host_valid = 1'b1;
      host_write = 1'b1;
      tick();
      host_write = 1'b0;
      tick();
      host_valid = 1'b0;
      checkOutput("ar_count_before", fifo_count, 2);
      tick();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("ar_count", fifo_count, 0);
      checkOutput("ar_ready", host_ready, 1);
      checkOutput("ar_busy", busy, 0);
      checkOutput("ar_outs", {read_req, write_req, done, done_write, timeout}, 0);
      tick();
      reset = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         tick();
         seen |= done | timeout | read_req | write_req | busy;
      end
      checkOutput("ar_silent", seen, 0);
      applyStimulus(1'b1);
      serveOne(1'b1, "ar_recover");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
